// File: rtl/ddr_ia_loader.sv
// Input-activation tile loader: issues DDR4 reads through the MIG app port and writes
// the returned beats, in order, into the IA BRAM starting at address 0.
module ddr_ia_loader #(
    parameter int DDR_ADDR_WIDTH  = 28,
    parameter int DDR_DATA_WIDTH  = 512,
    parameter int addr_width_ia   = 11,
    parameter int ADDR_STEP       = 8,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [DDR_ADDR_WIDTH-1:0] base_addr,
    input  logic [addr_width_ia:0]    num_beats,
    output logic                      busy,
    output logic                      done,
    output logic                      len_error,
    input  logic                      c0_init_calib_complete,
    output logic [DDR_ADDR_WIDTH-1:0] c0_ddr4_app_addr,
    output logic [2:0]                c0_ddr4_app_cmd,
    output logic                      c0_ddr4_app_en,
    input  logic                      c0_ddr4_app_rdy,
    input  logic [DDR_DATA_WIDTH-1:0] c0_ddr4_app_rd_data,
    input  logic                      c0_ddr4_app_rd_data_valid,
    output logic                      ia_bram_we,
    output logic [addr_width_ia-1:0]  ia_bram_addr,
    output logic [DDR_DATA_WIDTH-1:0] ia_bram_wdata
);

    // state    | meaning
    // IDLE     | waiting for start; zero-length and oversize requests answered here
    // WAIT_CAL | request accepted, holding until DDR calibration completes
    // ISSUE    | issuing read commands, collecting returned beats
    // DRAIN    | all commands accepted, collecting remaining beats
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_CAL = 2'd1,
        S_ISSUE    = 2'd2,
        S_DRAIN    = 2'd3
    } state_t;

    localparam int CW = addr_width_ia + 1;
    localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [CW-1:0] CAPACITY = {1'b1, {addr_width_ia{1'b0}}};
    localparam logic [OW-1:0] OUT_MAX  = OW'(MAX_OUTSTANDING);
    localparam logic [DDR_ADDR_WIDTH-1:0] STEP = DDR_ADDR_WIDTH'(ADDR_STEP);

    state_t                      state_q, state_d;
    logic [DDR_ADDR_WIDTH-1:0]   app_addr_q, app_addr_d;
    logic [CW-1:0]               num_q, num_d;
    logic [CW-1:0]               issued_q, issued_d;
    logic [CW-1:0]               received_q, received_d;
    logic [OW-1:0]               outst_q, outst_d;
    logic                        done_q, done_d;
    logic                        len_err_q, len_err_d;
    logic                        we_q, we_d;
    logic [addr_width_ia-1:0]    waddr_q, waddr_d;
    logic [DDR_DATA_WIDTH-1:0]   wdata_q, wdata_d;

    logic          app_en;
    logic          accept;
    logic          rd_ok;
    logic          start_ok;
    logic [CW-1:0] issued_inc;

    assign accept     = app_en & c0_ddr4_app_rdy;
    assign rd_ok      = c0_ddr4_app_rd_data_valid & ((state_q == S_ISSUE) | (state_q == S_DRAIN));
    assign start_ok   = start & (num_beats != '0) & (num_beats <= CAPACITY);
    assign issued_inc = issued_q + 1'b1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            app_addr_q <= '0;
            num_q      <= '0;
            issued_q   <= '0;
            received_q <= '0;
            outst_q    <= '0;
            done_q     <= 1'b0;
            len_err_q  <= 1'b0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            app_addr_q <= app_addr_d;
            num_q      <= num_d;
            issued_q   <= issued_d;
            received_q <= received_d;
            outst_q    <= outst_d;
            done_q     <= done_d;
            len_err_q  <= len_err_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:     if (start_ok) state_d = S_WAIT_CAL;
            S_WAIT_CAL: if (c0_init_calib_complete) state_d = S_ISSUE;
            S_ISSUE:    if (accept && (issued_inc == num_q)) state_d = S_DRAIN;
            S_DRAIN:    if (received_q == num_q) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        app_en = (state_q == S_ISSUE) && (issued_q < num_q) && (outst_q < OUT_MAX);
        busy   = (state_q != S_IDLE);
    end

    always_comb begin
        app_addr_d = app_addr_q;
        num_d      = num_q;
        issued_d   = issued_q;
        received_d = received_q;
        outst_d    = outst_q;
        done_d     = 1'b0;
        len_err_d  = 1'b0;
        we_d       = rd_ok;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;

        if (state_q == S_IDLE && start) begin
            if (num_beats == '0) begin
                done_d = 1'b1;
            end else if (num_beats > CAPACITY) begin
                len_err_d = 1'b1;
            end else begin
                num_d      = num_beats;
                app_addr_d = base_addr;
                issued_d   = '0;
                received_d = '0;
                outst_d    = '0;
            end
        end

        // Received count already includes the final beat while its BRAM write is visible.
        if (state_q == S_DRAIN && received_q == num_q) begin
            done_d = 1'b1;
        end

        if (accept) begin
            app_addr_d = app_addr_q + STEP;
            issued_d   = issued_inc;
        end

        if (rd_ok) begin
            waddr_d    = received_q[addr_width_ia-1:0];
            wdata_d    = c0_ddr4_app_rd_data;
            received_d = received_q + 1'b1;
        end

        unique case ({accept, rd_ok})
            2'b10:   outst_d = outst_q + 1'b1;
            2'b01:   outst_d = outst_q - 1'b1;
            default: outst_d = outst_q;
        endcase
    end

    assign done             = done_q;
    assign len_error        = len_err_q;
    assign c0_ddr4_app_addr = app_addr_q;
    assign c0_ddr4_app_cmd  = 3'b001;
    assign c0_ddr4_app_en   = app_en;
    assign ia_bram_we       = we_q;
    assign ia_bram_addr     = waddr_q;
    assign ia_bram_wdata    = wdata_q;

endmodule

// File: tb/tb_ddr_ia_loader.sv
// Directed bench for ddr_ia_loader with a small in-order DDR read responder.
module tb_ddr_ia_loader;

    logic         clock;
    logic         reset;
    logic         start;
    logic [27:0]  base_addr;
    logic [11:0]  num_beats;
    logic         busy;
    logic         done;
    logic         len_error;
    logic         calib;
    logic [27:0]  app_addr;
    logic [2:0]   app_cmd;
    logic         app_en;
    logic         app_rdy;
    logic [511:0] rd_data;
    logic         rd_valid;
    logic         we;
    logic [10:0]  waddr;
    logic [511:0] wdata;

    ddr_ia_loader dut (
        .clock                     (clock),
        .reset                     (reset),
        .start                     (start),
        .base_addr                 (base_addr),
        .num_beats                 (num_beats),
        .busy                      (busy),
        .done                      (done),
        .len_error                 (len_error),
        .c0_init_calib_complete    (calib),
        .c0_ddr4_app_addr          (app_addr),
        .c0_ddr4_app_cmd           (app_cmd),
        .c0_ddr4_app_en            (app_en),
        .c0_ddr4_app_rdy           (app_rdy),
        .c0_ddr4_app_rd_data       (rd_data),
        .c0_ddr4_app_rd_data_valid (rd_valid),
        .ia_bram_we                (we),
        .ia_bram_addr              (waddr),
        .ia_bram_wdata             (wdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    int cyc = 0;
    int lat = 10;
    bit rdy_rand = 0;
    bit hold_valid = 0;
    bit expect_wr = 0;
    bit done_seen = 0;
    logic [27:0] exp_base = '0;
    int exp_n = 0;
    int n_acc = 0, n_wr = 0, n_done = 0, n_en = 0, n_lerr = 0, outst = 0;
    int last_wr_cyc = 0;
    logic [10:0] last_wr_addr = '0;
    logic prev_en = 0, prev_rdy = 0;
    logic [27:0] prev_addr = '0;
    logic [27:0] rq_addr[$];
    int rq_due[$];

    task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] beat_of(input logic [27:0] a);
        return {16{4'hC, a}};
    endfunction

    task automatic step();
        logic acc;
        logic [27:0] ea;
        @(negedge clock);
        cyc++;
        if (prev_en && !prev_rdy && reset) begin
            check_eq("en_hold", 512'(app_en), 512'(1));
            check_eq("addr_hold", 512'(app_addr), 512'(prev_addr));
        end
        if (app_en) n_en++;
        if (len_error) n_lerr++;
        if (we) begin
            if (!expect_wr) begin
                check_eq("stray_we", 512'(1), 512'(0));
            end else begin
                ea = exp_base + 28'(n_wr * 8);
                check_eq("wr_addr", 512'(waddr), 512'(n_wr % 2048));
                check_eq("wr_data", wdata, beat_of(ea));
                last_wr_cyc = cyc;
                last_wr_addr = waddr;
                n_wr++;
            end
        end
        if (done) begin
            n_done++;
            if (!done_seen) begin
                done_seen = 1;
                if (exp_n > 0) begin
                    check_eq("done_lat", 512'(cyc - last_wr_cyc), 512'(1));
                    check_eq("wr_count", 512'(n_wr), 512'(exp_n));
                    check_eq("cmd_count", 512'(n_acc), 512'(exp_n));
                end
                check_eq("busy_at_done", 512'(busy), 512'(0));
            end
            expect_wr = 0;
        end else if (expect_wr && !done_seen) begin
            check_eq("busy", 512'(busy), 512'(1));
        end

        app_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        acc = app_en && app_rdy && reset;
        if (acc) begin
            check_eq("cmd_extra", 512'(n_acc < exp_n), 512'(1));
            check_eq("cmd_addr", 512'(app_addr), 512'(exp_base + 28'(n_acc * 8)));
            check_eq("cmd_code", 512'(app_cmd), 512'(3'b001));
            rq_addr.push_back(app_addr);
            rq_due.push_back(cyc + lat);
            n_acc++;
            outst++;
            check_eq("outst_max", 512'(outst <= 16), 512'(1));
        end
        prev_en = app_en;
        prev_rdy = app_rdy;
        prev_addr = app_addr;

        if (!hold_valid && rq_addr.size() > 0 && rq_due[0] <= cyc) begin
            rd_valid = 1'b1;
            rd_data = beat_of(rq_addr.pop_front());
            void'(rq_due.pop_front());
            outst--;
        end else begin
            rd_valid = 1'b0;
        end
    endtask

    task automatic start_load(input logic [27:0] base, input int num, input bit active);
        exp_base = base;
        exp_n = num;
        n_acc = 0; n_wr = 0; n_done = 0; n_en = 0; n_lerr = 0;
        done_seen = 0;
        expect_wr = active;
        start = 1'b1;
        base_addr = base;
        num_beats = 12'(num);
        step();
        start = 1'b0;
    endtask

    task automatic run_until_done(input int budget);
        int k = 0;
        while (!done_seen && k < budget) begin
            step();
            k++;
        end
        if (!done_seen) begin
            check_eq("timeout", 512'(0), 512'(1));
        end else begin
            repeat (3) step();
            check_eq("done_once", 512'(n_done), 512'(1));
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        base_addr = '0;
        num_beats = '0;
        calib = 1'b1;
        app_rdy = 1'b0;
        rd_valid = 1'b0;
        rd_data = '0;
        repeat (3) @(negedge clock);
        check_eq("rst_busy", 512'(busy), 512'(0));
        check_eq("rst_done", 512'(done), 512'(0));
        check_eq("rst_en", 512'(app_en), 512'(0));
        check_eq("rst_we", 512'(we), 512'(0));
        check_eq("rst_app_addr", 512'(app_addr), 512'(0));
        check_eq("rst_cmd", 512'(app_cmd), 512'(3'b001));
        reset = 1'b1;
        repeat (2) step();

        // basic 4-beat load
        start_load(28'h100, 4, 1);
        run_until_done(200);

        // outstanding cap with returns withheld
        hold_valid = 1;
        start_load(28'h2000, 40, 1);
        repeat (60) step();
        check_eq("cap_cmds", 512'(n_acc), 512'(16));
        check_eq("cap_en_low", 512'(app_en), 512'(0));
        hold_valid = 0;
        run_until_done(500);

        // random app_rdy back-pressure
        rdy_rand = 1;
        start_load(28'h4000, 20, 1);
        run_until_done(1000);
        rdy_rand = 0;

        // zero length, oversize, full tile
        start_load(28'h300, 0, 0);
        check_eq("zero_done", 512'(n_done), 512'(1));
        check_eq("zero_busy", 512'(busy), 512'(0));
        repeat (5) step();
        check_eq("zero_no_en", 512'(n_en), 512'(0));
        start_load(28'h300, 2049, 0);
        check_eq("len_err", 512'(n_lerr), 512'(1));
        repeat (5) step();
        check_eq("len_err_once", 512'(n_lerr), 512'(1));
        check_eq("len_no_en", 512'(n_en), 512'(0));
        check_eq("len_no_done", 512'(n_done), 512'(0));
        start_load(28'h10000, 2048, 1);
        run_until_done(5000);
        check_eq("full_last_addr", 512'(last_wr_addr), 512'(11'h7FF));

        // calibration held low
        calib = 1'b0;
        start_load(28'h500, 6, 1);
        repeat (50) step();
        check_eq("cal_no_en", 512'(n_en), 512'(0));
        calib = 1'b1;
        run_until_done(200);

        // reset in the middle of a load
        start_load(28'h800, 8, 1);
        begin
            int k = 0;
            while (n_wr < 3 && k < 100) begin
                step();
                k++;
            end
        end
        check_eq("mid_wr3", 512'(n_wr), 512'(3));
        expect_wr = 0;
        reset = 1'b0;
        #1;
        check_eq("mid_busy", 512'(busy), 512'(0));
        check_eq("mid_en", 512'(app_en), 512'(0));
        check_eq("mid_we", 512'(we), 512'(0));
        check_eq("mid_addr", 512'(app_addr), 512'(0));
        check_eq("mid_waddr", 512'(waddr), 512'(0));
        check_eq("mid_wdata", wdata, 512'(0));
        check_eq("mid_done", 512'(done), 512'(0));
        repeat (2) step();
        reset = 1'b1;
        repeat (25) step();
        check_eq("late_dropped", 512'(n_wr), 512'(3));
        rq_addr.delete();
        rq_due.delete();
        outst = 0;
        start_load(28'h900, 8, 1);
        run_until_done(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
